// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CHECK
  } state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int START_IDX      = 0;
  localparam int PAR_IDX        = DATA_WIDTH_DEF + 1;

  function automatic logic prescale_legal(input int p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Bundle between the receive FSM (slave) and its line/checker environment (master).
// frame_err exists only when UART_RX_FRAME_ERR_EN is defined.
interface uart_rx_fsm_if #(
  parameter int PRESCALE_WIDTH = 6
);
  import uart_rx_pkg::*;

  logic                      RX_IN;
  logic                      PAR_EN;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      strt_glitch_chk;
  logic                      par_err;
  logic                      stp_err;

  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [3:0]                bit_cnt;
  logic                      dat_samp_en;
  logic                      strt_chk_en;
  logic                      par_chk_en;
  logic                      stp_chk_en;
  logic                      deser_en;
  // data_valid is a single-cycle strobe with no ready: the consumer must take it that cycle.
  logic                      data_valid;
`ifdef UART_RX_FRAME_ERR_EN
  logic [1:0]                frame_err;
`endif
  state_t                    state;

  modport master (
    output RX_IN, PAR_EN, Prescale, strt_glitch_chk, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
    input  deser_en, data_valid,
`ifdef UART_RX_FRAME_ERR_EN
    input  frame_err,
`endif
    input  state
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale, strt_glitch_chk, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
    output deser_en, data_valid,
`ifdef UART_RX_FRAME_ERR_EN
    output frame_err,
`endif
    output state
  );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter; bit_done strobes on the last edge of a bit.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_MAX        = PAR_IDX + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      bit_done
);

  logic [PRESCALE_WIDTH-1:0] last;

  assign last     = prescale - PRESCALE_WIDTH'(1);
  assign bit_done = en && (edge_cnt == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= 4'(START_IDX);
    end else if (clear) begin
      edge_cnt <= '0;
      bit_cnt  <= 4'(START_IDX);
    end else if (en) begin
      if (bit_done) begin
        edge_cnt <= '0;
        // Saturate so the index cannot run past the final stop position.
        if (bit_cnt != 4'(BIT_MAX)) bit_cnt <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: sequences sampler, checkers and deserializer per frame.
// Define UART_RX_FRAME_ERR_EN to report parity/stop/glitch errors on frame_err.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input logic          CLK_fsm,
  input logic          RST_fsm,
  uart_rx_fsm_if.slave bus
);

  localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_WIDTH);

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] pres_q;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] edge_q;
  logic [3:0]                bit_q;
  logic                      par_en_q;
  logic                      cnt_en;
  logic                      cnt_clear;
  logic                      bit_done;
  logic                      pre_mid;
  logic                      stop_exit;
  logic                      frame_ok;

  // Enables are registered, so they are launched one edge early to land on H+2.
  assign half      = pres_q >> 1;
  assign pre_mid   = (edge_q == half + PRESCALE_WIDTH'(1));
  assign stop_exit = (edge_q == half + PRESCALE_WIDTH'(3));
  assign frame_ok  = !bus.stp_err && !(par_en_q && bus.par_err);
  assign cnt_en    = (state != IDLE);
  assign cnt_clear = (state == CHECK) || ((state == START) && bit_done && bus.strt_glitch_chk);

  uart_rx_edge_bit_counter #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .BIT_MAX       (DATA_WIDTH + 2)
  ) u_cnt (
    .clk     (CLK_fsm),
    .rst     (RST_fsm),
    .en      (cnt_en),
    .clear   (cnt_clear),
    .prescale(pres_q),
    .edge_cnt(edge_q),
    .bit_cnt (bit_q),
    .bit_done(bit_done)
  );

  assign bus.edge_cnt = edge_q;
  assign bus.bit_cnt  = bit_q;
  assign bus.state    = state;

  always_ff @(posedge CLK_fsm or posedge RST_fsm) begin
    if (RST_fsm) begin
      state           <= IDLE;
      pres_q          <= '0;
      par_en_q        <= 1'b0;
      bus.dat_samp_en <= 1'b0;
      bus.strt_chk_en <= 1'b0;
      bus.par_chk_en  <= 1'b0;
      bus.stp_chk_en  <= 1'b0;
      bus.deser_en    <= 1'b0;
      bus.data_valid  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      bus.frame_err   <= 2'b00;
`endif
    end else begin
      bus.dat_samp_en <= 1'b0;
      bus.strt_chk_en <= 1'b0;
      bus.par_chk_en  <= 1'b0;
      bus.stp_chk_en  <= 1'b0;
      bus.deser_en    <= 1'b0;
      bus.data_valid  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      bus.frame_err   <= 2'b00;
`endif
      case (state)
        IDLE: begin
          // Frame configuration is frozen here for the whole frame.
          if (!bus.RX_IN) begin
            state           <= START;
            pres_q          <= bus.Prescale;
            par_en_q        <= bus.PAR_EN;
            bus.dat_samp_en <= 1'b1;
          end
        end
        START: begin
          bus.dat_samp_en <= 1'b1;
          bus.strt_chk_en <= pre_mid;
          if (bit_done) begin
            if (bus.strt_glitch_chk) begin
              state           <= IDLE;
              bus.dat_samp_en <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
              bus.frame_err   <= 2'b11;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          bus.dat_samp_en <= 1'b1;
          bus.deser_en    <= pre_mid;
          if (bit_done && (bit_q == LAST_DATA_IDX)) state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          bus.dat_samp_en <= 1'b1;
          bus.par_chk_en  <= pre_mid;
          if (bit_done) state <= STOP;
        end
        STOP: begin
          bus.dat_samp_en <= 1'b1;
          bus.stp_chk_en  <= pre_mid;
          // Stop-check result is registered by now; verdict shows in the CHECK cycle.
          if (stop_exit) begin
            state          <= CHECK;
            bus.data_valid <= frame_ok;
`ifdef UART_RX_FRAME_ERR_EN
            bus.frame_err  <= {bus.stp_err, par_en_q & bus.par_err};
`endif
          end
        end
        CHECK: begin
          if (!bus.RX_IN) begin
            state           <= START;
            bus.dat_samp_en <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
